// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants, iterative FSM states and S-box tables
//
// Purpose : common definitions for the AES round engines.
// Contents: state_t (128-bit state), byte_t (8-bit byte), AES_NB_BYTES,
//           iter_state_e (IDLE/BUSY/DONE for multi-cycle engines),
//           SBOX (forward) and INV_SBOX (inverse) FIPS-197 tables.
// Ports   : none (package).

package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    localparam int AES_NB_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } iter_state_e;

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box lookup
//
// Purpose: one byte through the FIPS-197 inverse S-box.
// Ports  : value - input byte
//          subst - InvSbox(value)

module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] subst
);

    assign subst = INV_SBOX[value];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - iterative AES InvSubBytes engine, LANES bytes per cycle
//
// Purpose: accepts a 128-bit state, substitutes LANES bytes per beat through
//          LANES inverse S-boxes over NBEATS = 16/LANES beats, then presents
//          the result until the downstream takes it.
// Ports  : clk, rst (sync, active-high)
//          in_valid/in_ready/in_state   - input state handshake
//          out_valid/out_ready/out_state - result handshake
//          busy - high while a block is in flight (BUSY or DONE)
// Macro  : INV_SUB_BYTES_OUTREG_EN - registers the S-box outputs before the
//          result write; adds one drain beat (latency NBEATS+1).

module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NBEATS = AES_NB_BYTES / LANES;

`ifdef INV_SUB_BYTES_OUTREG_EN
    // Beat counter also covers the drain beat, so it must reach NBEATS.
    localparam int             CW        = $clog2(NBEATS + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(NBEATS);
`else
    localparam int             CW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0]  LAST_BEAT = CW'(NBEATS - 1);
`endif

    iter_state_e   state_q;
    iter_state_e   state_d;
    logic [CW-1:0] beat_q;
    state_t        buf_q;
    state_t        result_q;
    logic [4:0]    rd_beat;
    byte_t         sb [LANES];

`ifdef INV_SUB_BYTES_OUTREG_EN
    byte_t         sb_q [LANES];

    // The drain beat has no bytes of its own to read; park the lookup on beat 0.
    assign rd_beat = (beat_q == LAST_BEAT) ? 5'd0 : 5'(beat_q);
`else
    assign rd_beat = 5'(beat_q);
`endif

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [4:0] rd_idx;

        assign rd_idx = 5'(int'(rd_beat) * LANES + j);

        inv_sbox u_inv_sbox (
            .value (buf_q[8*rd_idx +: 8]),
            .subst (sb[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = BUSY;
            BUSY:    if (beat_q == LAST_BEAT) state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            BUSY:    busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    assign out_state = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q   <= '0;
            buf_q    <= '0;
            result_q <= '0;
`ifdef INV_SUB_BYTES_OUTREG_EN
            for (int j = 0; j < LANES; j++) begin
                sb_q[j] <= '0;
            end
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        buf_q  <= in_state;
                        beat_q <= '0;
                    end
                end
                BUSY: begin
                    // Hold at the last beat so the counter never wraps.
                    if (beat_q != LAST_BEAT) begin
                        beat_q <= beat_q + 1'b1;
                    end
`ifdef INV_SUB_BYTES_OUTREG_EN
                    sb_q <= sb;
                    // Registered lookups land one beat behind the read.
                    if (beat_q != '0) begin
                        for (int j = 0; j < LANES; j++) begin
                            result_q[8*((int'(beat_q) - 1) * LANES + j) +: 8] <= sb_q[j];
                        end
                    end
`else
                    for (int j = 0; j < LANES; j++) begin
                        result_q[8*(int'(beat_q) * LANES + j) +: 8] <= sb[j];
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse of the forward SubBytes stage.
- Accepts a 128-bit state on a valid/ready handshake.
- Substitutes LANES bytes per cycle through the inverse S-box.
- Presents the 128-bit result on a valid/ready output handshake.
- Trades area (LANES S-box copies instead of 16) for latency; sits between InvShiftRows and AddRoundKey in the decrypt round.

Parameters:
LANES, 4, inverse S-boxes instantiated; legal values 1, 2, 4, 8, 16; number of substitution beats NBEATS = 16/LANES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  in_state valid
in_ready  output  1  block can accept a state
in_state  input  128  state to substitute; byte i = in_state[8*i +: 8]
out_valid  output  1  out_state valid
out_ready  input  1  downstream accepts out_state
out_state  output  128  substituted state; byte i = InvSbox(in byte i)
busy  output  1  high in BUSY or DONE

Behaviour:
- One clock; reset is synchronous and active-high; ports are clk and rst. While rst is high at a rising edge:
  - FSM goes to IDLE; beat counter = 0.
  - Result and input buffers clear to 0.
  - Outputs: out_valid=0, out_state=0, in_ready=1, busy=0.
- Reset mid-operation abandons the block; no output is produced for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state into the input buffer, beat=0, go to BUSY.
  - in_state is ignored otherwise.
- BUSY:
  - in_ready=0.
  - Each cycle, for lanes j=0..LANES-1, byte index k = beat*LANES + j; result[8*k +: 8] <= InvSbox(buf[8*k +: 8]); beat increments.
  - When beat == NBEATS-1, that final beat is written and the FSM goes to DONE.
  - Beat counter width is clog2(NBEATS) with a minimum of 1 bit; no wrap occurs inside BUSY.
  - LANES=16: exactly one BUSY cycle.
- DONE:
  - out_valid=1; out_state = result, held stable until handshake.
  - On out_ready: go to IDLE next cycle, out_valid deasserts.
  - out_ready low: hold indefinitely (backpressure); in_valid is ignored.
- Latency: in handshake at edge T → out_valid high after edge T+NBEATS (LANES=4: 4 cycles).
- Throughput: one block per NBEATS+2 cycles with out_ready held high.
- out_valid never deasserts without a handshake or rst.
- out_state keeps its last value in IDLE; its value there is don't-care to consumers.
- in_valid while busy is not an error; the upstream must hold it until in_ready.
- Inverse S-box: full FIPS-197 inverse table, 256 entries, combinational. Examples: 0x63→0x00, 0x7c→0x01, 0x52→0x00? No: 0x00→0x52, 0x16→0xff.

Optional Feature:
INV_SUB_BYTES_OUTREG_EN
- Defined:
  - Inverse S-box outputs are registered before the write into result, breaking the critical path.
  - BUSY lasts NBEATS+1 cycles (one drain cycle); DONE entry is delayed one cycle.
  - Latency becomes NBEATS+1.
- Undefined: behaviour as above, with no extra register.

Decomposition:
- Shared package aes_pkg:
  - typedef state_t (128-bit) and byte_t (8-bit);
  - constant AES_NB_BYTES=16;
  - FSM state enum for iterative engines (IDLE/BUSY/DONE);
  - inverse S-box constant table, alongside the forward table.
- Sub-module inv_sbox: 8-bit in → 8-bit out, purely combinational, instantiated LANES times via generate.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, busy=0, out_state=0.
- in_state bytes 0..15 = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76 (byte 0 = 0x63), out_ready=1 → out_state bytes = 00 01 … 0f, out_valid exactly 4 cycles after accept (LANES=4).
- in_state = all 0x00 → all 0x52; in_state = all 0x16 → all 0xff.
- Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new state → out_state stable, in_ready=0; after out_ready=1, block returns to IDLE and accepts the new state.
- Assert rst for one cycle during beat 2 → next cycle IDLE, out_valid=0; the following block completes correctly.
- Sweep all 256 byte values (16 per block, 16 blocks) with LANES ∈ {1, 16} and with INV_SUB_BYTES_OUTREG_EN → forward-Sbox(out) == input, latencies 16/1 and 17/2.
